// File: rtl/sparc_mem_ctrl_pkg.sv
// Shared definitions for the SPARC memory controller: access sizes, FSM states,
// wait-counter width and the alignment rule.
package sparc_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Wait counter covers WAIT_CYCLES in 0..15.
  localparam int unsigned CNT_W = 4;

  // Halfwords need an even address, words a 4-byte aligned one; the reserved
  // size is always rejected.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return |off;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/sparc_mem_lane.sv
// Byte-lane steering for a big-endian 32-bit word: write replication and lane
// enables, read selection with zero/sign extension, and the misalignment flag.
module sparc_mem_lane
  import sparc_mem_ctrl_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  off,
  input  logic        se,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] wword,
  output logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        mis
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // be[i] enables byte offset i inside the word; offset 0 is the MSB lane.
  always_comb begin
    wword = '0;
    be    = '0;
    rdata = '0;
    rbyte = '0;
    rhalf = '0;
    mis   = is_misaligned(size, off);
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << off;
        wword = {4{wdata[7:0]}};
        rbyte = 8'(rword >> {~off, 3'b000});
        rdata = {{24{se & rbyte[7]}}, rbyte};
      end
      SZ_HALF: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rhalf = off[1] ? rword[15:0] : rword[31:16];
        rdata = {{16{se & rhalf[15]}}, rhalf};
      end
      SZ_WORD: begin
        be    = 4'b1111;
        wword = wdata;
        rdata = rword;
      end
      default: ;
    endcase
    if (mis) be = '0;
  end

endmodule

// File: rtl/sparc_mem_ctrl.sv
// SPARC-style memory controller: captures a request, inserts WAIT_CYCLES wait
// states, performs the byte-array access and handshakes completion with MOC/MAE.
module sparc_mem_ctrl
  import sparc_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_BYTES = 512,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              mov,
  input  logic              r_w,
  // 'type' is a reserved word in SystemVerilog; the access-size port is acc_type.
  input  logic [1:0]        acc_type,
  input  logic              se,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              MOC,
  output logic              MAE,
  output logic              busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);

  logic [7:0] mem [DEPTH_BYTES];

  state_e           state, state_nxt;
  logic [CNT_W-1:0] wcnt;
  logic             capture, enter_done;

  logic             cap_rw, cap_se;
  logic [1:0]       cap_type;
  logic [IDX_W-1:0] cap_idx;
  logic [31:0]      cap_data;

  logic             op_rw, op_se;
  logic [1:0]       op_type;
  logic [IDX_W-1:0] op_idx;
  logic [31:0]      op_data;

  logic [IDX_W-3:0] word_idx;
  logic [31:0]      rword, wword, rdata;
  logic [3:0]       be;
  logic             mis;

  // Address bits above the storage size wrap silently.
  if (ADDR_W > IDX_W) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[ADDR_W-1:IDX_W];
  end

  // With WAIT_CYCLES=0 DONE is entered on the capture edge itself, so the
  // access must see the live inputs while idle and the captured copy afterwards.
  always_comb begin
    if (state == S_IDLE) begin
      op_rw   = r_w;
      op_se   = se;
      op_type = acc_type;
      op_idx  = addr[IDX_W-1:0];
      op_data = data_in;
    end else begin
      op_rw   = cap_rw;
      op_se   = cap_se;
      op_type = cap_type;
      op_idx  = cap_idx;
      op_data = cap_data;
    end
  end

  assign word_idx = op_idx[IDX_W-1:2];
  assign rword    = {mem[{word_idx, 2'd0}], mem[{word_idx, 2'd1}],
                     mem[{word_idx, 2'd2}], mem[{word_idx, 2'd3}]};

  sparc_mem_lane u_lane (
    .size  (size_e'(op_type)),
    .off   (op_idx[1:0]),
    .se    (op_se),
    .wdata (op_data),
    .rword (rword),
    .wword (wword),
    .be    (be),
    .rdata (rdata),
    .mis   (mis)
  );

  // Next-state logic and the capture / DONE-entry strobes.
  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    enter_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (mov) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nxt  = S_DONE;
            enter_done = 1'b1;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wcnt <= CNT_W'(1)) begin
          state_nxt  = S_DONE;
          enter_done = 1'b1;
        end
      end
      S_DONE: begin
        if (!mov) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // State register.
  always_ff @(posedge Clk) begin
    if (!Clr) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Wait-state down-counter, loaded on capture.
  always_ff @(posedge Clk) begin
    if (!Clr)                 wcnt <= '0;
    else if (capture)         wcnt <= CNT_W'(WAIT_CYCLES);
    else if (state == S_WAIT) wcnt <= wcnt - 1'b1;
  end

  // Request capture; later input changes cannot disturb the operation.
  always_ff @(posedge Clk) begin
    if (capture) begin
      cap_rw   <= r_w;
      cap_se   <= se;
      cap_type <= acc_type;
      cap_idx  <= addr[IDX_W-1:0];
      cap_data <= data_in;
    end
  end

  // Read data and MAE update on DONE entry; MOC follows one cycle later and
  // drops together with MAE on the return to IDLE.
  always_ff @(posedge Clk) begin
    if (!Clr) begin
      data_out <= '0;
      MOC      <= 1'b0;
      MAE      <= 1'b0;
    end else begin
      if (enter_done) begin
        MAE <= mis;
        if (op_rw && !mis) data_out <= rdata;
      end
      if (state == S_DONE) begin
        if (mov) begin
          MOC <= 1'b1;
        end else begin
          MOC <= 1'b0;
          MAE <= 1'b0;
        end
      end
    end
  end

  // Storage write on DONE entry; storage itself is never reset.
  always_ff @(posedge Clk) begin
    if (Clr && enter_done && !op_rw) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[{word_idx, 2'(i)}] <= wword[8*(3-i) +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sparc_mem_ctrl.sv
// Self-checking bench for sparc_mem_ctrl: one instance with 3 wait states, one
// with none; directed vector table, reset-abort sequence and random traffic
// checked against a byte-array reference model.
module tb_sparc_mem_ctrl;

  localparam int unsigned W_A   = 3;
  localparam int unsigned W_B   = 0;
  localparam int unsigned DEPTH = 512;

  logic Clk = 1'b0;
  logic Clr;
  always #5 Clk = ~Clk;

  logic [1:0]       mov, r_w, se, moc, mae, busy;
  logic [1:0][1:0]  typ;
  logic [1:0][31:0] addr, din, dout;

  sparc_mem_ctrl #(.ADDR_W(32), .DEPTH_BYTES(DEPTH), .WAIT_CYCLES(W_A)) u_a (
    .Clk(Clk), .Clr(Clr), .mov(mov[0]), .r_w(r_w[0]), .acc_type(typ[0]), .se(se[0]),
    .addr(addr[0]), .data_in(din[0]), .data_out(dout[0]), .MOC(moc[0]), .MAE(mae[0]),
    .busy(busy[0]));

  sparc_mem_ctrl #(.ADDR_W(32), .DEPTH_BYTES(DEPTH), .WAIT_CYCLES(W_B)) u_b (
    .Clk(Clk), .Clr(Clr), .mov(mov[1]), .r_w(r_w[1]), .acc_type(typ[1]), .se(se[1]),
    .addr(addr[1]), .data_in(din[1]), .data_out(dout[1]), .MOC(moc[1]), .MAE(mae[1]),
    .busy(busy[1]));

  int n_run  = 0;
  int n_fail = 0;

  // Reference model of instance A: plain byte array plus last read value.
  logic [7:0]  ref_mem [DEPTH];
  logic [31:0] ref_dout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_op(input logic rw, input logic [1:0] t, input logic sx,
                                   input logic [31:0] a, input logic [31:0] dd,
                                   output logic exp_mae);
    int unsigned n, ea;
    logic [31:0] v;
    n  = (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
    ea = a % DEPTH;
    exp_mae = (t == 2'd3) || (ea % n != 0);
    if (exp_mae) return;
    if (!rw) begin
      for (int unsigned k = 0; k < n; k++)
        ref_mem[ea+k] = 8'(dd >> (8 * (n - 1 - k)));
    end else begin
      v = '0;
      for (int unsigned k = 0; k < n; k++) v = (v << 8) | 32'(ref_mem[ea+k]);
      if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      ref_dout = v;
    end
  endfunction

  // One complete handshake on instance d; inputs are scrambled after capture.
  task automatic do_op(input int d, input logic rw, input logic [1:0] t, input logic sx,
                       input logic [31:0] a, input logic [31:0] dd, input int hold,
                       output logic [31:0] o_dout, output logic o_mae);
    int lat;
    int wexp;
    wexp = int'(d == 0 ? W_A : W_B) + 1;
    @(negedge Clk);
    r_w[d] = rw; typ[d] = t; se[d] = sx; addr[d] = a; din[d] = dd; mov[d] = 1'b1;
    @(posedge Clk); #1;
    chk("busy_after_capture", 32'(busy[d]), 32'd1);
    r_w[d] = 1'($urandom); typ[d] = 2'($urandom); se[d] = 1'($urandom);
    addr[d] = $urandom; din[d] = $urandom;
    lat = 0;
    while (moc[d] !== 1'b1 && lat < 32) begin
      @(posedge Clk); #1;
      lat++;
    end
    chk("moc_latency", 32'(lat), 32'(wexp));
    o_dout = dout[d];
    o_mae  = mae[d];
    for (int i = 0; i < hold; i++) begin
      @(posedge Clk); #1;
      chk("moc_hold", 32'(moc[d]), 32'd1);
    end
    mov[d] = 1'b0;
    @(posedge Clk); #1;
    chk("moc_fall", 32'(moc[d]), 32'd0);
    chk("busy_idle", 32'(busy[d]), 32'd0);
    chk("mae_clear", 32'(mae[d]), 32'd0);
  endtask

  typedef struct {
    logic        rw;
    logic [1:0]  t;
    logic        sx;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_dout;
    logic        exp_mae;
  } vec_t;

  vec_t vt [22];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] o_d;
    logic        o_m, e_m;
    logic [31:0] w;

    //            rw    t     se    addr           data           dout           mae
    vt[0]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vt[1]  = '{1'b1, 2'd0, 1'b1, 32'h0000_0010, 32'h0,         32'hFFFF_FFDE, 1'b0};
    vt[2]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0011, 32'h0,         32'h0000_00AD, 1'b0};
    vt[3]  = '{1'b1, 2'd1, 1'b1, 32'h0000_0012, 32'h0,         32'hFFFF_BEEF, 1'b0};
    vt[4]  = '{1'b1, 2'd2, 1'b1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vt[5]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0012, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1};
    vt[6]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vt[7]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0011, 32'h0,         32'hDEAD_BEEF, 1'b1};
    vt[8]  = '{1'b1, 2'd3, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b1};
    vt[9]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0204, 32'h0000_00A5, 32'hDEAD_BEEF, 1'b0};
    vt[10] = '{1'b1, 2'd0, 1'b0, 32'h0000_0004, 32'h0,         32'h0000_00A5, 1'b0};
    vt[11] = '{1'b1, 2'd0, 1'b1, 32'hFFFF_FE04, 32'h0,         32'hFFFF_FFA5, 1'b0};
    vt[12] = '{1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, 32'hFFFF_FFA5, 1'b0};
    vt[13] = '{1'b0, 2'd1, 1'b0, 32'h0000_0022, 32'hFFFF_7F01, 32'hFFFF_FFA5, 1'b0};
    vt[14] = '{1'b1, 2'd2, 1'b0, 32'h0000_0020, 32'h0,         32'hCAFE_7F01, 1'b0};
    vt[15] = '{1'b1, 2'd1, 1'b1, 32'h0000_0022, 32'h0,         32'h0000_7F01, 1'b0};
    vt[16] = '{1'b0, 2'd0, 1'b0, 32'h0000_0023, 32'h1234_5680, 32'h0000_7F01, 1'b0};
    vt[17] = '{1'b1, 2'd2, 1'b0, 32'h0000_0020, 32'h0,         32'hCAFE_7F80, 1'b0};
    vt[18] = '{1'b1, 2'd1, 1'b0, 32'h0000_0021, 32'h0,         32'hCAFE_7F80, 1'b1};
    vt[19] = '{1'b1, 2'd0, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_00CA, 1'b0};
    vt[20] = '{1'b1, 2'd1, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_DEAD, 1'b0};
    vt[21] = '{1'b1, 2'd0, 1'b1, 32'h0000_0013, 32'h0,         32'hFFFF_FFEF, 1'b0};

    Clr = 1'b0;
    mov = '0; r_w = '0; se = '0; typ = '0; addr = '0; din = '0;
    ref_dout = '0;

    // Reset state of both instances.
    repeat (3) @(posedge Clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_moc",  32'(moc[d]),  32'd0);
      chk("rst_mae",  32'(mae[d]),  32'd0);
      chk("rst_busy", 32'(busy[d]), 32'd0);
      chk("rst_dout", dout[d],      32'd0);
    end
    @(negedge Clk);
    Clr = 1'b1;

    // Fill instance A with known contents.
    for (int unsigned i = 0; i < DEPTH / 4; i++) begin
      w = $urandom;
      do_op(0, 1'b0, 2'd2, 1'b0, 32'(i * 4), w, 0, o_d, o_m);
      model_op(1'b0, 2'd2, 1'b0, 32'(i * 4), w, e_m);
      chk("init_mae", 32'(o_m), 32'd0);
    end

    // Directed vectors.
    for (int i = 0; i < 22; i++) begin
      do_op(0, vt[i].rw, vt[i].t, vt[i].sx, vt[i].a, vt[i].d, i % 3, o_d, o_m);
      model_op(vt[i].rw, vt[i].t, vt[i].sx, vt[i].a, vt[i].d, e_m);
      chk($sformatf("vec%0d_dout", i), o_d, vt[i].exp_dout);
      chk($sformatf("vec%0d_mae", i), 32'(o_m), 32'(vt[i].exp_mae));
    end

    // Reset while waiting aborts the write of 0x11223344 @0x20.
    @(negedge Clk);
    r_w[0] = 1'b0; typ[0] = 2'd2; se[0] = 1'b0; addr[0] = 32'h20; din[0] = 32'h1122_3344;
    mov[0] = 1'b1;
    @(posedge Clk); #1;
    chk("abort_busy_wait", 32'(busy[0]), 32'd1);
    @(negedge Clk);
    Clr = 1'b0;
    @(posedge Clk); #1;
    chk("abort_moc",  32'(moc[0]),  32'd0);
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_dout", dout[0],      32'd0);
    mov[0] = 1'b0;
    ref_dout = '0;
    @(negedge Clk);
    Clr = 1'b1;
    repeat (4) @(posedge Clk);
    do_op(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0, 1, o_d, o_m);
    model_op(1'b1, 2'd2, 1'b0, 32'h20, 32'h0, e_m);
    chk("abort_readback", o_d, 32'hCAFE_7F80);
    chk("abort_readback_mae", 32'(o_m), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      logic        rw, sx;
      logic [1:0]  t;
      logic [31:0] a, dd;
      rw = 1'($urandom_range(0, 1));
      t  = 2'($urandom_range(0, 3));
      sx = 1'($urandom_range(0, 1));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      dd = $urandom;
      do_op(0, rw, t, sx, a, dd, int'($urandom_range(0, 2)), o_d, o_m);
      model_op(rw, t, sx, a, dd, e_m);
      chk("rand_mae", 32'(o_m), 32'(e_m));
      chk("rand_dout", o_d, ref_dout);
    end

    // Zero wait states on instance B.
    do_op(1, 1'b0, 2'd1, 1'b0, 32'h2, 32'h0000_BEEF, 0, o_d, o_m);
    chk("w0_write_mae", 32'(o_m), 32'd0);
    do_op(1, 1'b1, 2'd1, 1'b0, 32'h2, 32'h0, 1, o_d, o_m);
    chk("w0_read_half", o_d, 32'h0000_BEEF);
    chk("w0_read_mae", 32'(o_m), 32'd0);
    do_op(1, 1'b1, 2'd0, 1'b1, 32'h3, 32'h0, 0, o_d, o_m);
    chk("w0_read_byte_se", o_d, 32'hFFFF_FFEF);
    do_op(1, 1'b1, 2'd2, 1'b0, 32'h2, 32'h0, 0, o_d, o_m);
    chk("w0_misaligned_mae", 32'(o_m), 32'd1);
    chk("w0_misaligned_dout", o_d, 32'hFFFF_FFEF);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
